// File: rtl/ones_pattern_tx.sv
// Serial test-pattern transmitter: count (0..10) in, 10-bit word with that many ones out MSB-first.
// Optional build macro ONES_PATTERN_TX_ROTATE_EN rotates each loaded pattern right by a per-accept counter.
module ones_pattern_tx #(
  parameter int WIDTH = 10,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_last,
  output logic [WIDTH-1:0] out_word,
  output logic             err
);

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [CNT_W-1:0] MAXN = CNT_W'(WIDTH);
  localparam logic [3:0]       LAST = 4'(WIDTH-1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [3:0]       idx_q, idx_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] n;
  logic [WIDTH-1:0] base, pat;
  logic             accept, xfer;

`ifdef ONES_PATTERN_TX_ROTATE_EN
  logic [3:0] rot_q;

  // Right rotation: result bit j takes source bit (j + r) mod WIDTH.
  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] v, input logic [3:0] r);
    logic [WIDTH-1:0] o;
    int s;
    o = '0;
    for (int j = 0; j < WIDTH; j++) begin
      s = j + int'(r);
      if (s >= WIDTH) s = s - WIDTH;
      o[j] = v[s];
    end
    return o;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rot_q <= '0;
    else if (accept) rot_q <= (rot_q == LAST) ? 4'd0 : rot_q + 4'd1;
  end

  assign pat = rotr(base, rot_q);
`else
  assign pat = base;
`endif

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SHIFT);
  assign out_bit   = out_valid & shreg_q[WIDTH-1];
  assign out_last  = out_valid & (idx_q == LAST);
  assign out_word  = word_q;
  assign err       = err_q;
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign n         = (in_count > MAXN) ? MAXN : in_count;

  // N ones packed into the MSBs.
  always_comb begin
    base = '0;
    for (int i = 0; i < WIDTH; i++) base[WIDTH-1-i] = (i < int'(n));
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = SHIFT;
        shreg_d = pat;
        word_d  = pat;
        idx_d   = '0;
        err_d   = (in_count > MAXN);
      end
      SHIFT: if (xfer) begin
        shreg_d = shreg_q << 1;
        idx_d   = idx_q + 4'd1;
        if (idx_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      word_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

endmodule
